// File: rtl/simple_tx_fifo_pkg.sv
// ----------------------------------------------------------------------
// simple_tx_fifo_pkg : register map, status/ctrl bits, response codes
// rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package simple_tx_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ACK  = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ACK  = 2'd1,
    RD_RESP = 2'd2
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/simple_tx_fifo_core.sv
// ----------------------------------------------------------------------
// simple_tx_fifo_core : first-word-fall-through FIFO on one inferred RAM
// rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module simple_tx_fifo_core #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  // Callers only assert push/pop when legal; flush overrides any same-cycle pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/simple_tx_fifo.sv
// ----------------------------------------------------------------------
// simple_tx_fifo : AXI4-Lite push side, AXI4-Stream pop side TX buffer
// rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module simple_tx_fifo
  import simple_tx_fifo_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH           = 1024
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [1:0]                      bresp_q, bresp_d;
  logic [C_S00_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                            ovf_q, ovf_d;

  logic [CW-1:0] w_count;
  logic          w_full, w_empty;
  logic          w_wr_hs, w_rd_hs, w_pop, w_room;
  logic          w_is_data, w_is_ctrl, w_push, w_drop, w_flush;
  logic          w_unused;

  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb,
                      s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign s00_axi_awready = (wr_state_q == WR_ACK);
  assign s00_axi_wready  = (wr_state_q == WR_ACK);
  assign s00_axi_bvalid  = (wr_state_q == WR_RESP);
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = (rd_state_q == RD_ACK);
  assign s00_axi_rvalid  = (rd_state_q == RD_RESP);
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = RESP_OKAY;

  assign w_wr_hs = s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid;
  assign w_rd_hs = s00_axi_arready && s00_axi_arvalid;

  // A full FIFO still takes a push when the stream drains a word on the same edge.
  assign m_axis_tvalid = !w_empty;
  assign w_pop     = m_axis_tvalid && m_axis_tready;
  assign w_room    = !w_full || w_pop;
  assign w_is_data = w_wr_hs && (s00_axi_awaddr[3:2] == REG_DATA);
  assign w_is_ctrl = w_wr_hs && (s00_axi_awaddr[3:2] == REG_CTRL);
  assign w_push    = w_is_data && w_room;
  assign w_drop    = w_is_data && !w_room;
  assign w_flush   = w_is_ctrl && s00_axi_wdata[CTRL_FLUSH];

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WR_IDLE: if (s00_axi_awvalid && s00_axi_wvalid) wr_state_d = WR_ACK;
      WR_ACK:  wr_state_d = w_wr_hs ? WR_RESP : WR_IDLE;
      WR_RESP: if (s00_axi_bready) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RD_IDLE: if (s00_axi_arvalid) rd_state_d = RD_ACK;
      RD_ACK:  rd_state_d = w_rd_hs ? RD_RESP : RD_IDLE;
      RD_RESP: if (s00_axi_rready) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    bresp_d = bresp_q;
    ovf_d   = ovf_q;
    rdata_d = rdata_q;
    if (w_wr_hs) bresp_d = w_drop ? RESP_SLVERR : RESP_OKAY;
    if (w_is_ctrl && s00_axi_wdata[CTRL_CLR_OVF]) ovf_d = 1'b0;
    if (w_drop) ovf_d = 1'b1;
    if (w_rd_hs) begin
      rdata_d = '0;
      unique case (s00_axi_araddr[3:2])
        REG_COUNT:  rdata_d[CW-1:0] = w_count;
        REG_STATUS: begin
          rdata_d[STAT_EMPTY] = w_empty;
          rdata_d[STAT_FULL]  = w_full;
          rdata_d[STAT_OVF]   = ovf_q;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      bresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      ovf_q      <= ovf_d;
    end
  end

  simple_tx_fifo_core #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (C_S00_AXI_DATA_WIDTH)
  ) u_core (
    .clk_i   (s00_axi_aclk),
    .rst_i   (s00_axi_areset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .wdata_i (s00_axi_wdata),
    .rdata_o (m_axis_tdata),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

endmodule

`default_nettype wire
